// File: rtl/pcie_axis_chan_mux_if.sv
// AXI-Stream bundle with LANES parallel streams packed side by side.
// Lane i occupies slice i of every field.
interface pcie_axis_chan_mux_if #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned LANES      = 1
);
  logic [LANES-1:0]              tvalid;
  logic [LANES-1:0]              tready;
  logic [LANES*DATA_WIDTH-1:0]   tdata;
  logic [LANES*DATA_WIDTH/8-1:0] tkeep;
  logic [LANES-1:0]              tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/pcie_axis_chan_mux.sv
// PCIe DMA stream switch: H2C packets steered to a channel by a header ID, and C2H packets
// from all channels merged by packet-granular round-robin.
module pcie_axis_chan_mux #(
  parameter int unsigned DATA_WIDTH  = 256,
  parameter int unsigned NUM_CHAN    = 4,
  parameter int unsigned CHAN_ID_LSB = 0,
  parameter int unsigned CHAN_ID_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_i,
  pcie_axis_chan_mux_if.slave  s_h2c,
  pcie_axis_chan_mux_if.master m_chan,
  pcie_axis_chan_mux_if.slave  s_chan,
  pcie_axis_chan_mux_if.master m_c2h,
  output logic [31:0]          drop_cnt_o,
  output logic [3:0]           c2h_grant_o
);
  localparam int unsigned KeepW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {StHead, StBody, StDrop} h2c_st_e;
  typedef enum logic {StArb, StGrant} c2h_st_e;

  h2c_st_e        h2c_st_q;
  logic [3:0]     route_q;
  logic [31:0]    drop_cnt_q;
  c2h_st_e        c2h_st_q;
  logic [3:0]     rr_ptr_q;
  logic [3:0]     grant_q;

  logic [CHAN_ID_W-1:0] hdr_id;
  logic [31:0]          hdr_id_ext;
  logic                 hdr_ok;
  logic [3:0]           sel;
  logic                 route_en;
  logic                 drop_en;
  logic                 h2c_hs;

  assign hdr_id     = s_h2c.tdata[CHAN_ID_LSB +: CHAN_ID_W];
  assign hdr_id_ext = 32'(hdr_id);
  assign hdr_ok     = hdr_id_ext < NUM_CHAN;

  always_comb begin
    route_en = 1'b0;
    drop_en  = 1'b0;
    sel      = route_q;
    unique case (h2c_st_q)
      StHead: begin
        sel      = hdr_id_ext[3:0];
        route_en = enable_i && hdr_ok;
        drop_en  = enable_i && !hdr_ok;
      end
      StBody:  route_en = 1'b1;
      StDrop:  drop_en  = 1'b1;
      default: ;
    endcase
    m_chan.tvalid  = '0;
    s_h2c.tready   = drop_en;
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (route_en && sel == 4'(i)) begin
        m_chan.tvalid[i] = s_h2c.tvalid[0];
        s_h2c.tready     = m_chan.tready[i];
      end
    end
  end

  // Payload is broadcast; only tvalid selects the destination.
  assign m_chan.tdata = {NUM_CHAN{s_h2c.tdata}};
  assign m_chan.tkeep = {NUM_CHAN{s_h2c.tkeep}};
  assign m_chan.tlast = {NUM_CHAN{s_h2c.tlast}};

  assign h2c_hs = s_h2c.tvalid[0] && s_h2c.tready[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h2c_st_q   <= StHead;
      route_q    <= '0;
      drop_cnt_q <= '0;
    end else if (h2c_hs) begin
      unique case (h2c_st_q)
        StHead: begin
          if (!hdr_ok && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 32'd1;
          if (!s_h2c.tlast[0]) begin
            h2c_st_q <= hdr_ok ? StBody : StDrop;
            route_q  <= sel;
          end
        end
        StBody, StDrop: if (s_h2c.tlast[0]) h2c_st_q <= StHead;
        default: h2c_st_q <= StHead;
      endcase
    end
  end

  logic [NUM_CHAN-1:0] rot;
  logic [4:0]          pick_sum;
  logic [3:0]          pick;
  logic                any_req;
  logic                c2h_hs;

  // Rotate requests so bit 0 is the rr_ptr channel; the lowest set bit wins.
  always_comb begin
    rot = (s_chan.tvalid >> rr_ptr_q) | (s_chan.tvalid << (5'(NUM_CHAN) - {1'b0, rr_ptr_q}));
    pick_sum = {1'b0, rr_ptr_q};
    for (int k = int'(NUM_CHAN) - 1; k >= 0; k--) begin
      if (rot[k]) pick_sum = {1'b0, rr_ptr_q} + 5'(k);
    end
    pick = (pick_sum >= 5'(NUM_CHAN)) ? 4'(pick_sum - 5'(NUM_CHAN)) : pick_sum[3:0];
  end

  assign any_req = |s_chan.tvalid;

  always_comb begin
    m_c2h.tvalid  = '0;
    m_c2h.tdata   = '0;
    m_c2h.tkeep   = '0;
    m_c2h.tlast   = '0;
    s_chan.tready = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (grant_q == 4'(i)) begin
        m_c2h.tdata    = s_chan.tdata[i*DATA_WIDTH +: DATA_WIDTH];
        m_c2h.tkeep    = s_chan.tkeep[i*KeepW +: KeepW];
        m_c2h.tlast[0] = s_chan.tlast[i];
        if (c2h_st_q == StGrant) begin
          m_c2h.tvalid[0]  = s_chan.tvalid[i];
          s_chan.tready[i] = m_c2h.tready[0];
        end
      end
    end
  end

  assign c2h_hs = m_c2h.tvalid[0] && m_c2h.tready[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c2h_st_q <= StArb;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      unique case (c2h_st_q)
        StArb: begin
          if (enable_i && any_req) begin
            grant_q  <= pick;
            c2h_st_q <= StGrant;
          end
        end
        StGrant: begin
          if (c2h_hs && m_c2h.tlast[0]) begin
            rr_ptr_q <= (grant_q == 4'(NUM_CHAN - 1)) ? 4'd0 : grant_q + 4'd1;
            c2h_st_q <= StArb;
          end
        end
        default: c2h_st_q <= StArb;
      endcase
    end
  end

  assign drop_cnt_o  = drop_cnt_q;
  assign c2h_grant_o = grant_q;
endmodule

// File: tb/tb_pcie_axis_chan_mux.sv
// Self-checking bench: packet-level reference model for H2C routing/drops and C2H round-robin.
module tb_pcie_axis_chan_mux;
  localparam int DW = 64;
  localparam int NC = 4;
  localparam int KW = DW / 8;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [31:0] drop_cnt;
  logic [3:0]  c2h_grant;

  int errors = 0;
  int checks = 0;
  int exp_drop = 0;
  int exp_rr = 0;

  int          q_id[$];
  int          q_len[$];
  int          c_npk[NC];
  int          c_len[NC][8];
  logic [31:0] salt;
  int          c2h_order[$];

  pcie_axis_chan_mux_if #(.DATA_WIDTH(DW), .LANES(1))  h2c_if ();
  pcie_axis_chan_mux_if #(.DATA_WIDTH(DW), .LANES(NC)) mchan_if ();
  pcie_axis_chan_mux_if #(.DATA_WIDTH(DW), .LANES(NC)) schan_if ();
  pcie_axis_chan_mux_if #(.DATA_WIDTH(DW), .LANES(1))  c2h_if ();

  pcie_axis_chan_mux #(
    .DATA_WIDTH (DW),
    .NUM_CHAN   (NC),
    .CHAN_ID_LSB(0),
    .CHAN_ID_W  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable_i   (enable),
    .s_h2c      (h2c_if),
    .m_chan     (mchan_if),
    .s_chan     (schan_if),
    .m_c2h      (c2h_if),
    .drop_cnt_o (drop_cnt),
    .c2h_grant_o(c2h_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [DW-1:0] c_data(input int ch, input int pk, input int bt);
    return {salt, 8'(ch), 8'(pk), 16'(bt)};
  endfunction

  function automatic logic [KW-1:0] c_keep(input int ch, input int pk, input int bt);
    return KW'(ch * 37 + pk * 5 + bt + 1);
  endfunction

  // H2C engine. mode 0: all ready; 1: channel 1 stalls cycles 2..6; 2: random everything.
  task automatic run_h2c(input int mode, input int max_cycles, output int stalls);
    int pk, bt, cyc, dest;
    bit first, hs, exp_last;
    logic v, exp_tr;
    logic [NC-1:0] mtr, exp_mv;
    logic [DW-1:0] cur;
    pk = 0; bt = 0; cyc = 0; stalls = 0;
    cur = rnd_word();
    if (q_id.size() > 0) cur[7:0] = 8'(q_id[0]);
    while (pk < q_id.size() && cyc < max_cycles) begin
      @(negedge clk);
      first    = (bt == 0);
      dest     = (q_id[pk] < NC) ? q_id[pk] : -1;
      exp_last = (bt == q_len[pk] - 1);
      v        = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      enable   = (mode == 2) ? ($urandom_range(0, 4) != 0) : 1'b1;
      mtr      = '1;
      if (mode == 1 && cyc >= 2 && cyc < 7) mtr[1] = 1'b0;
      if (mode == 2) mtr = NC'($urandom());
      h2c_if.tvalid   = v;
      h2c_if.tdata    = cur;
      h2c_if.tkeep    = cur[15:8];
      h2c_if.tlast    = exp_last;
      mchan_if.tready = mtr;
      #1;
      exp_mv = '0;
      exp_tr = 1'b0;
      if (first && !enable) begin
        exp_tr = 1'b0;
      end else if (dest >= 0) begin
        exp_mv[dest] = v;
        exp_tr       = mtr[dest];
      end else begin
        exp_tr = 1'b1;
      end
      checks++;
      if (mchan_if.tvalid !== exp_mv) begin
        errors++;
        $display("FAIL h2c_route pkt=%0d beat=%0d m_chan_tvalid=%b expected=%b",
                 pk, bt, mchan_if.tvalid, exp_mv);
      end
      checks++;
      if (h2c_if.tready[0] !== exp_tr) begin
        errors++;
        $display("FAIL h2c_tready pkt=%0d beat=%0d got=%b expected=%b",
                 pk, bt, h2c_if.tready[0], exp_tr);
      end
      if (v && dest >= 0) begin
        checks++;
        if (mchan_if.tdata[dest*DW +: DW] !== cur || mchan_if.tlast[dest] !== exp_last ||
            mchan_if.tkeep[dest*KW +: KW] !== cur[15:8]) begin
          errors++;
          $display("FAIL h2c_payload ch=%0d data=%h last=%b expected data=%h last=%b",
                   dest, mchan_if.tdata[dest*DW +: DW], mchan_if.tlast[dest], cur, exp_last);
        end
      end
      hs = v && (h2c_if.tready[0] === 1'b1);
      if (v && !hs) stalls++;
      @(posedge clk);
      if (hs) begin
        if (first && dest < 0) exp_drop++;
        bt++;
        cur = rnd_word();
        if (bt == q_len[pk]) begin
          bt = 0;
          pk++;
          if (pk < q_id.size()) cur[7:0] = 8'(q_id[pk]);
        end
      end
      cyc++;
    end
    @(negedge clk);
    h2c_if.tvalid   = 1'b0;
    mchan_if.tready = '1;
    checks++;
    if (pk != q_id.size()) begin
      errors++;
      $display("FAIL h2c_timeout packets_done=%0d expected=%0d", pk, q_id.size());
    end
    checks++;
    if (drop_cnt !== 32'(exp_drop)) begin
      errors++;
      $display("FAIL drop_cnt got=%0d expected=%0d", drop_cnt, exp_drop);
    end
    q_id.delete();
    q_len.delete();
  endtask

  // C2H engine. mode 0: always ready; 1: random ready/enable; 2: enable low cycles 2..9.
  task automatic run_c2h(input int mode, input int max_cycles, output int cycles);
    int pki[NC], bti[NC];
    bit in_pkt, pend, exp_last;
    int mch, cyc, pick;
    logic rdy;
    logic [NC-1:0] exp_tr;
    for (int c = 0; c < NC; c++) begin
      pki[c] = 0;
      bti[c] = 0;
    end
    in_pkt = 0; mch = 0; cyc = 0;
    c2h_order.delete();
    pend = 1;
    while (cyc < max_cycles) begin
      pend = 0;
      for (int c = 0; c < NC; c++) if (pki[c] < c_npk[c]) pend = 1;
      if (!pend && !in_pkt) break;
      @(negedge clk);
      if (mode == 1) enable = ($urandom_range(0, 7) != 0);
      else if (mode == 2) enable = !(cyc >= 2 && cyc < 10);
      else enable = 1'b1;
      for (int c = 0; c < NC; c++) begin
        if (pki[c] < c_npk[c]) begin
          schan_if.tvalid[c]          = 1'b1;
          schan_if.tdata[c*DW +: DW]  = c_data(c, pki[c], bti[c]);
          schan_if.tkeep[c*KW +: KW]  = c_keep(c, pki[c], bti[c]);
          schan_if.tlast[c]           = (bti[c] == c_len[c][pki[c]] - 1);
        end else begin
          schan_if.tvalid[c] = 1'b0;
          schan_if.tlast[c]  = 1'b0;
        end
      end
      rdy = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
      c2h_if.tready = rdy;
      #1;
      if (!in_pkt) begin
        checks++;
        if (c2h_if.tvalid[0] !== 1'b0 || schan_if.tready !== '0) begin
          errors++;
          $display("FAIL c2h_idle cyc=%0d m_c2h_tvalid=%b s_chan_tready=%b expected 0/0000",
                   cyc, c2h_if.tvalid[0], schan_if.tready);
        end
      end else begin
        exp_tr      = '0;
        exp_tr[mch] = rdy;
        exp_last    = (bti[mch] == c_len[mch][pki[mch]] - 1);
        checks++;
        if (c2h_if.tvalid[0] !== 1'b1 || c2h_grant !== 4'(mch)) begin
          errors++;
          $display("FAIL c2h_grant cyc=%0d tvalid=%b grant=%0d expected 1/%0d",
                   cyc, c2h_if.tvalid[0], c2h_grant, mch);
        end
        checks++;
        if (c2h_if.tdata !== c_data(mch, pki[mch], bti[mch]) ||
            c2h_if.tkeep !== c_keep(mch, pki[mch], bti[mch]) || c2h_if.tlast[0] !== exp_last) begin
          errors++;
          $display("FAIL c2h_payload ch=%0d data=%h last=%b expected data=%h last=%b", mch,
                   c2h_if.tdata, c2h_if.tlast[0], c_data(mch, pki[mch], bti[mch]), exp_last);
        end
        checks++;
        if (schan_if.tready !== exp_tr) begin
          errors++;
          $display("FAIL c2h_src_ready cyc=%0d got=%b expected=%b", cyc, schan_if.tready, exp_tr);
        end
      end
      @(posedge clk);
      if (!in_pkt) begin
        if (enable) begin
          pick = -1;
          for (int k = 0; k < NC; k++) begin
            int c;
            c = (exp_rr + k) % NC;
            if (pick < 0 && pki[c] < c_npk[c]) pick = c;
          end
          if (pick >= 0) begin
            in_pkt = 1;
            mch = pick;
            c2h_order.push_back(pick);
          end
        end
      end else if (rdy) begin
        bti[mch]++;
        if (bti[mch] == c_len[mch][pki[mch]]) begin
          bti[mch] = 0;
          pki[mch]++;
          exp_rr = (mch + 1) % NC;
          in_pkt = 0;
        end
      end
      cyc++;
    end
    cycles = cyc;
    @(negedge clk);
    schan_if.tvalid = '0;
    enable = 1'b1;
    checks++;
    if (pend || in_pkt) begin
      errors++;
      $display("FAIL c2h_timeout cycles=%0d expected all packets drained", cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    h2c_if.tvalid   = 1'b1;
    h2c_if.tdata    = '0;
    schan_if.tvalid = '1;
    #1;
    checks++;
    if (mchan_if.tvalid !== '0 || h2c_if.tready[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_h2c m_chan_tvalid=%b s_h2c_tready=%b expected 0000/0",
               mchan_if.tvalid, h2c_if.tready[0]);
    end
    checks++;
    if (c2h_if.tvalid[0] !== 1'b0 || schan_if.tready !== '0) begin
      errors++;
      $display("FAIL reset_c2h m_c2h_tvalid=%b s_chan_tready=%b expected 0/0000",
               c2h_if.tvalid[0], schan_if.tready);
    end
    checks++;
    if (c2h_grant !== 4'd0 || drop_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_regs grant=%0d drop_cnt=%0d expected 0/0", c2h_grant, drop_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_drop = 0;
    exp_rr = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (c2h_if.tvalid[0] !== 1'b0 || h2c_if.tready[0] !== 1'b0 || mchan_if.tvalid !== '0) begin
      errors++;
      $display("FAIL disabled_idle m_c2h_tvalid=%b s_h2c_tready=%b m_chan_tvalid=%b expected 0",
               c2h_if.tvalid[0], h2c_if.tready[0], mchan_if.tvalid);
    end
    h2c_if.tvalid   = 1'b0;
    schan_if.tvalid = '0;
  endtask

  task automatic test_h2c_route();
    int st;
    q_id.push_back(2); q_len.push_back(4);
    run_h2c(0, 50, st);
    checks++;
    if (st != 0) begin
      errors++;
      $display("FAIL h2c_route_stalls got=%0d expected=0", st);
    end
  endtask

  task automatic test_h2c_drop();
    int st;
    q_id.push_back(9); q_len.push_back(3);
    q_id.push_back(0); q_len.push_back(2);
    run_h2c(0, 50, st);
    checks++;
    if (drop_cnt !== 32'd1) begin
      errors++;
      $display("FAIL h2c_drop_count got=%0d expected=1", drop_cnt);
    end
  endtask

  task automatic test_h2c_backpressure();
    int st;
    q_id.push_back(1); q_len.push_back(8);
    run_h2c(1, 50, st);
    checks++;
    if (st != 5) begin
      errors++;
      $display("FAIL h2c_backpressure_stalls got=%0d expected=5", st);
    end
  endtask

  task automatic test_reset_mid_packet();
    @(negedge clk);
    enable          = 1'b1;
    mchan_if.tready = '1;
    h2c_if.tvalid   = 1'b1;
    h2c_if.tdata    = 64'h1234_5678_0000_0003;
    h2c_if.tlast    = 1'b0;
    #1;
    checks++;
    if (mchan_if.tvalid !== 4'b1000) begin
      errors++;
      $display("FAIL rst_mid_head m_chan_tvalid=%b expected=1000", mchan_if.tvalid);
    end
    @(negedge clk);
    h2c_if.tdata = 64'h0000_0000_0000_00F0;
    #1;
    checks++;
    if (mchan_if.tvalid !== 4'b1000) begin
      errors++;
      $display("FAIL rst_mid_body m_chan_tvalid=%b expected=1000", mchan_if.tvalid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mchan_if.tvalid !== '0 || h2c_if.tready[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_clear m_chan_tvalid=%b s_h2c_tready=%b expected 0000/1",
               mchan_if.tvalid, h2c_if.tready[0]);
    end
    @(negedge clk);
    h2c_if.tvalid = 1'b0;
    rst = 1'b0;
    exp_drop = 0;
    exp_rr = 0;
    @(negedge clk);
    h2c_if.tvalid = 1'b1;
    h2c_if.tdata  = 64'hABCD_0000_0000_0001;
    h2c_if.tlast  = 1'b1;
    #1;
    checks++;
    if (mchan_if.tvalid !== 4'b0010 || drop_cnt !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid_next_header m_chan_tvalid=%b drop_cnt=%0d expected 0010/0",
               mchan_if.tvalid, drop_cnt);
    end
    @(negedge clk);
    h2c_if.tvalid = 1'b0;
    h2c_if.tlast  = 1'b0;
  endtask

  task automatic test_c2h_round_robin();
    int cyc;
    salt = $urandom();
    for (int c = 0; c < NC; c++) begin
      c_npk[c] = 2;
      for (int p = 0; p < 8; p++) c_len[c][p] = 2;
    end
    run_c2h(0, 200, cyc);
    checks++;
    if (cyc != 24 || c2h_order.size() != 8) begin
      errors++;
      $display("FAIL c2h_rr_timing cycles=%0d packets=%0d expected 24/8", cyc, c2h_order.size());
    end
    for (int i = 0; i < 5 && i < c2h_order.size(); i++) begin
      checks++;
      if (c2h_order[i] != i % NC) begin
        errors++;
        $display("FAIL c2h_rr_order idx=%0d got=%0d expected=%0d", i, c2h_order[i], i % NC);
      end
    end
  endtask

  task automatic test_c2h_enable();
    int cyc;
    salt = $urandom();
    c_npk = '{1, 1, 0, 0};
    c_len[0][0] = 3;
    c_len[1][0] = 2;
    run_c2h(2, 100, cyc);
    checks++;
    if (cyc != 13 || c2h_order.size() != 2) begin
      errors++;
      $display("FAIL c2h_enable_timing cycles=%0d packets=%0d expected 13/2",
               cyc, c2h_order.size());
    end else begin
      checks++;
      if (c2h_order[0] != 0 || c2h_order[1] != 1) begin
        errors++;
        $display("FAIL c2h_enable_order got=%0d,%0d expected=0,1", c2h_order[0], c2h_order[1]);
      end
    end
  endtask

  task automatic test_c2h_random();
    int cyc;
    for (int r = 0; r < 3; r++) begin
      salt = $urandom();
      for (int c = 0; c < NC; c++) begin
        c_npk[c] = $urandom_range(0, 3);
        for (int p = 0; p < 8; p++) c_len[c][p] = $urandom_range(1, 4);
      end
      run_c2h(1, 600, cyc);
    end
  endtask

  task automatic test_h2c_random();
    int st;
    for (int i = 0; i < 40; i++) begin
      q_id.push_back($urandom_range(0, 11));
      q_len.push_back($urandom_range(1, 5));
    end
    run_h2c(2, 3000, st);
  endtask

  initial begin
    rst             = 1'b1;
    enable          = 1'b0;
    h2c_if.tvalid   = 1'b0;
    h2c_if.tdata    = '0;
    h2c_if.tkeep    = '0;
    h2c_if.tlast    = 1'b0;
    mchan_if.tready = '1;
    schan_if.tvalid = '0;
    schan_if.tdata  = '0;
    schan_if.tkeep  = '0;
    schan_if.tlast  = '0;
    c2h_if.tready   = 1'b1;
    test_reset();
    test_h2c_route();
    test_h2c_drop();
    test_h2c_backpressure();
    test_reset_mid_packet();
    test_c2h_round_robin();
    test_c2h_enable();
    test_c2h_random();
    test_h2c_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
